fourstate_lane_scanner: RTL and testbench

- Downstream consumer of the 4-state constant-pattern source stage. Takes its two outputs: the 5x4x1 lane vector and the 2x1 array of 3x2 words.
- On a start pulse, snapshots both inputs, then walks the 7 items (5 lanes, then 2 words) one at a time.
- Classifies every bit of the current item as 0/1/X/Z and emits one count record per item on a valid/ready port.
- Ends each scan with a one-cycle done pulse carrying the total number of unknown (X+Z) bits.
- Simulation-target block: classification uses case equality.

---
 rtl/fourstate_pkg.sv | 15 +
 rtl/fourstate_lane_scanner_if.sv | 13 +
 rtl/fourstate_bit_counter.sv | 26 ++
 rtl/fourstate_lane_scanner.sv | 104 ++++++++++
 tb/tb_fourstate_lane_scanner.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fourstate_pkg.sv
// fourstate_pkg: shared states, item geometry and count record for the lane scanner
package fourstate_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_e;
    localparam int LANE_W = 4;
    localparam int WORD_W = 6;
    localparam int N_ITEMS = 7;
    typedef struct packed {
        logic [2:0] idx;
        logic [2:0] width;
        logic [2:0] n0;
        logic [2:0] n1;
        logic [2:0] nx;
        logic [2:0] nz;
    } count_rec_t;
endpackage

// File: rtl/fourstate_lane_scanner_if.sv
// fourstate_lane_scanner_if: per-item count record valid/ready channel
interface fourstate_lane_scanner_if;
    logic out_valid;
    logic out_ready;
    logic [2:0] out_idx;
    logic [2:0] out_width;
    logic [2:0] out_n0;
    logic [2:0] out_n1;
    logic [2:0] out_nx;
    logic [2:0] out_nz;
    modport master (output out_valid, out_idx, out_width, out_n0, out_n1, out_nx, out_nz, input out_ready);
    modport slave (input out_valid, out_idx, out_width, out_n0, out_n1, out_nx, out_nz, output out_ready);
endinterface

// File: rtl/fourstate_bit_counter.sv
// fourstate_bit_counter: classifies the low width bits of a 4-state vector as 0/1/X/Z
module fourstate_bit_counter
    import fourstate_pkg::*;
(
    input  logic [5:0] v,
    input  logic [2:0] width,
    output logic [2:0] n0,
    output logic [2:0] n1,
    output logic [2:0] nx,
    output logic [2:0] nz
);
    // priority order keeps the four counts summing to width even on 2-state simulators
    always_comb begin
        n0 = '0;
        n1 = '0;
        nx = '0;
        nz = '0;
        for (int i = 0; i < WORD_W; i++)
            if (i < int'(width)) begin
                if (v[i] === 1'b0) n0 = n0 + 3'd1;
                else if (v[i] === 1'b1) n1 = n1 + 3'd1;
                else if (v[i] === 1'bx) nx = nx + 3'd1;
                else nz = nz + 3'd1;
            end
    end
endmodule

// File: rtl/fourstate_lane_scanner.sv
// fourstate_lane_scanner: snapshots lanes and words on start, emits one 0/1/X/Z count record
// per item, then pulses done with the saturated unknown-bit total
module fourstate_lane_scanner
    import fourstate_pkg::*;
#(
    parameter int N_LANES = 5,
    parameter int N_WORDS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic [0:N_LANES-1][4:1][2:2] lanes_in,
    input  logic [1:3][3:2] words_in [2:2+N_WORDS-1][0:0],
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    output logic [4:0] total_unknown,
    fourstate_lane_scanner_if.master rec
);
    state_e st, nxt;
    logic [0:N_LANES-1][4:1][2:2] lanes_q;
    logic [N_WORDS-1:0][5:0] words_q;
    logic [2:0] idx;
    logic [5:0] acc, nsum;
    logic [5:0] item;
    logic [2:0] width, c0, c1, cx, cz;
    logic hs, last, kill;
    assign hs = rec.out_valid && rec.out_ready;
    assign last = int'(idx) == N_LANES + N_WORDS - 1;
    assign kill = abort && st != IDLE;
    assign busy = st != IDLE;
    assign nsum = acc + 6'(rec.out_nx) + 6'(rec.out_nz);
    always_comb begin
        item = '0;
        for (int i = 0; i < N_LANES; i++)
            if (int'(idx) == i) item = {2'b00, lanes_q[i]};
        for (int i = 0; i < N_WORDS; i++)
            if (int'(idx) == N_LANES + i) item = words_q[i];
        width = int'(idx) < N_LANES ? 3'(LANE_W) : 3'(WORD_W);
    end
    fourstate_bit_counter u_cnt (.v(item), .width(width), .n0(c0), .n1(c1), .nx(cx), .nz(cz));
    always_ff @(posedge clk or posedge rst)
        if (rst) st <= IDLE;
        else st <= nxt;
    always_comb begin
        nxt = st;
        case (st)
            IDLE: nxt = start ? SCAN : IDLE;
            SCAN: nxt = EMIT;
            EMIT: nxt = hs ? (last ? DONE : SCAN) : EMIT;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (kill) nxt = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lanes_q <= '0;
            words_q <= '0;
            idx <= '0;
            acc <= '0;
            done <= 1'b0;
            total_unknown <= '0;
            rec.out_valid <= 1'b0;
            rec.out_idx <= '0;
            rec.out_width <= '0;
            rec.out_n0 <= '0;
            rec.out_n1 <= '0;
            rec.out_nx <= '0;
            rec.out_nz <= '0;
        end else if (kill) begin
            rec.out_valid <= 1'b0;
            done <= 1'b0;
        end else
            case (st)
                IDLE:
                    if (start) begin
                        lanes_q <= lanes_in;
                        for (int j = 0; j < N_WORDS; j++) words_q[j] <= words_in[2+j][0];
                        idx <= '0;
                        acc <= '0;
                    end
                SCAN: begin
                    rec.out_idx <= idx;
                    rec.out_width <= width;
                    rec.out_n0 <= c0;
                    rec.out_n1 <= c1;
                    rec.out_nx <= cx;
                    rec.out_nz <= cz;
                    rec.out_valid <= 1'b1;
                end
                EMIT:
                    if (hs) begin
                        acc <= nsum;
                        rec.out_valid <= 1'b0;
                        if (last) begin
                            done <= 1'b1;
                            total_unknown <= nsum > 6'd31 ? 5'd31 : nsum[4:0];
                        end else idx <= idx + 3'd1;
                    end
                DONE: done <= 1'b0;
                default: done <= 1'b0;
            endcase
endmodule

// File: tb/tb_fourstate_lane_scanner.sv
// tb_fourstate_lane_scanner: randomized scans checked against a per-item bit-classification model
module tb_fourstate_lane_scanner;
    import fourstate_pkg::*;
    logic clk, rst, start, abort, busy, done;
    logic [4:0] total_unknown;
    logic [0:4][4:1][2:2] lanes_in, lanes_m;
    logic [1:3][3:2] words_in [2:3][0:0];
    logic [1:3][3:2] words_m [2:3][0:0];
    int errors = 0, checks = 0;
    fourstate_lane_scanner_if bus ();
    fourstate_lane_scanner dut (
        .clk(clk), .rst(rst), .lanes_in(lanes_in), .words_in(words_in),
        .start(start), .abort(abort), .busy(busy), .done(done),
        .total_unknown(total_unknown), .rec(bus)
    );
    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic rnd4();
        case ($urandom % 4)
            0: return 1'b0;
            1: return 1'b1;
            2: return 1'bx;
            default: return 1'bz;
        endcase
    endfunction

    function automatic count_rec_t model(input int k);
        count_rec_t r;
        logic [5:0] v;
        int w;
        r = '0;
        w = k < 5 ? 4 : 6;
        if (k < 5) v = {2'b00, lanes_m[k]};
        else v = words_m[k-3][0];
        r.idx = 3'(k);
        r.width = 3'(w);
        for (int i = 0; i < w; i++) begin
            if (v[i] === 1'b0) r.n0++;
            else if (v[i] === 1'b1) r.n1++;
            else if (v[i] === 1'bx) r.nx++;
            else r.nz++;
        end
        return r;
    endfunction

    task automatic randomize_inputs();
        logic [5:0] v;
        for (int l = 0; l < 5; l++)
            for (int b = 1; b <= 4; b++) lanes_in[l][b] = rnd4();
        for (int w = 2; w <= 3; w++) begin
            for (int b = 0; b < 6; b++) v[b] = rnd4();
            words_in[w][0] = v;
        end
    endtask

    // mode 0: ready high, 1: 3-cycle stall on sitem, 2: random ready, 3: abort on sitem
    task automatic scan(input int mode, input int sitem, input bit noisy);
        count_rec_t e, got;
        int k, edges, stalls, hs_edge, held, acc, expe;
        bit hs, seen;
        logic [4:0] prev_total;
        lanes_m = lanes_in;
        words_m = words_in;
        prev_total = total_unknown;
        k = 0; edges = 1; stalls = 0; held = 0; acc = 0; hs_edge = 0; seen = 0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (noisy) begin
                start = 1'($urandom % 2);
                lanes_in = 'x;
                words_in[2][0] = 'x;
                words_in[3][0] = 'z;
            end
            e = model(k);
            if (bus.out_valid) begin
                got = {bus.out_idx, bus.out_width, bus.out_n0, bus.out_n1, bus.out_nx, bus.out_nz};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL record item %0d: got %h required %h", k, got, e);
                end
                if (!seen) begin
                    expe = k == 0 ? 2 : hs_edge + 1;
                    checks++;
                    if (edges != expe) begin
                        errors++;
                        $display("FAIL valid_latency item %0d: edge %0d required %0d", k, edges, expe);
                    end
                    seen = 1;
                end
                bus.out_ready = 1;
                if (mode == 1 && k == sitem && held < 3) begin
                    bus.out_ready = 0;
                    held++;
                end else if (mode == 2) bus.out_ready = ($urandom % 4) != 0;
                else if (mode == 3 && k == sitem) begin
                    if (held == 0) begin
                        bus.out_ready = 0;
                        held = 1;
                    end else abort = 1;
                end
            end else bus.out_ready = 1'($urandom % 2);
            hs = bus.out_valid && bus.out_ready;
            if (bus.out_valid && !bus.out_ready) stalls++;
            @(posedge clk); edges++; #1;
            if (abort) begin
                abort = 0;
                checks++;
                if (busy !== 0 || bus.out_valid !== 0 || done !== 0) begin
                    errors++;
                    $display("FAIL abort: busy=%b valid=%b done=%b required 0 0 0", busy, bus.out_valid, done);
                end
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (done !== 0 || busy !== 0 || total_unknown !== prev_total) begin
                        errors++;
                        $display("FAIL post_abort: done=%b busy=%b total=%0d required 0 0 %0d", done, busy, total_unknown, prev_total);
                    end
                end
                return;
            end
            if (hs) begin
                acc += e.nx + e.nz;
                k++;
                hs_edge = edges;
                seen = 0;
            end
            if (done) begin
                start = 0;
                expe = acc > 31 ? 31 : acc;
                checks++;
                if (k != 7 || edges != 15 + stalls || total_unknown !== 5'(expe) || busy !== 1) begin
                    errors++;
                    $display("FAIL done: items=%0d edge=%0d total=%0d busy=%b required 7 %0d %0d 1", k, edges, total_unknown, busy, 15 + stalls, expe);
                end
                @(posedge clk); #1;
                checks++;
                if (done !== 0 || busy !== 0 || total_unknown !== 5'(expe)) begin
                    errors++;
                    $display("FAIL done_pulse: done=%b busy=%b total=%0d required 0 0 %0d", done, busy, total_unknown, expe);
                end
                return;
            end
        end
        errors++;
        $display("FAIL timeout: items=%0d of 7 required done", k);
        start = 0;
    endtask

    task automatic test_reset();
        randomize_inputs();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1;
        start = 1;
        #1;
        checks++;
        if (busy !== 0 || bus.out_valid !== 0 || done !== 0 || total_unknown !== 0) begin
            errors++;
            $display("FAIL reset_async: busy=%b valid=%b done=%b total=%0d required all 0", busy, bus.out_valid, done, total_unknown);
        end
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 0 || bus.out_valid !== 0 || done !== 0) begin
                errors++;
                $display("FAIL reset_hold: busy=%b valid=%b done=%b required 0 0 0", busy, bus.out_valid, done);
            end
        end
        start = 0;
        rst = 0;
    endtask

    task automatic test_known();
        lanes_in = '0;
        words_in[2][0] = '1;
        words_in[3][0] = '1;
        scan(0, 0, 0);
    endtask

    task automatic test_mixed();
        randomize_inputs();
        for (int l = 0; l < 5; l++) lanes_in[l] = 4'($urandom);
        lanes_in[2] = 4'bx0z1;
        words_in[2][0] = 6'($urandom);
        words_in[3][0] = 6'bzzxx10;
        scan(0, 0, 0);
    endtask

    task automatic test_stall();
        randomize_inputs();
        scan(1, 3, 0);
    endtask

    task automatic test_snapshot();
        randomize_inputs();
        scan(0, 0, 1);
    endtask

    task automatic test_abort();
        randomize_inputs();
        scan(3, 4, 0);
        randomize_inputs();
        scan(0, 0, 0);
    endtask

    task automatic test_saturate();
        lanes_in = 'x;
        words_in[2][0] = 'z;
        words_in[3][0] = 'x;
        scan(0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            randomize_inputs();
            scan(2, 0, 0);
        end
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; bus.out_ready = 0;
        lanes_in = '0;
        words_in[2][0] = '0;
        words_in[3][0] = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 0 || bus.out_valid !== 0 || done !== 0 || total_unknown !== 0) begin
            errors++;
            $display("FAIL reset_initial: busy=%b valid=%b done=%b total=%0d required all 0", busy, bus.out_valid, done, total_unknown);
        end
        rst = 0;
        @(posedge clk); #1;
        test_reset();
        @(posedge clk); #1;
        test_known();
        test_mixed();
        test_stall();
        test_snapshot();
        test_abort();
        test_saturate();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
